ps2_scancode_decoder: RTL

- Sits directly downstream of the PS/2 byte receiver.
- Consumes validated Set-2 scancode bytes and resolves the `E0`, `F0` and `E1` prefix sequences into single key events.
- Tracks shift state, optionally translates keys to ASCII, and buffers events in a show-ahead FIFO for the game/display logic.
- Runs entirely in the system clock domain; the receiver's byte strobe is already synchronised into that domain.

---
 rtl/ps2_scancode_decoder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode parser: resolves E0/F0/E1 prefixes into key events, tracks shift and queues events in a show-ahead FIFO.
// Optional ASCII translation is compiled in with `define SCANCODE_ASCII_EN; otherwise ev_ascii is always 0.
module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keycode,
    input  logic       code_valid,
    input  logic       ev_rd,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_rel,
    output logic [7:0] ev_ascii,
    output logic       ev_full,
    output logic       overflow,
    output logic       shift_held
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_E0   = 3'd1;
    localparam logic [2:0] ST_F0   = 3'd2;
    localparam logic [2:0] ST_E0F0 = 3'd3;
    localparam logic [2:0] ST_SKIP = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [2:0]       skip_cnt_q, skip_cnt_d;
    logic             shift_l_q, shift_l_d;
    logic             shift_r_q, shift_r_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [17:0]      mem_q [FIFO_DEPTH];
    logic [17:0]      mem_d [FIFO_DEPTH];

    logic             ev_gen;
    logic             new_ext;
    logic             new_rel;
    logic [7:0]       new_code;
    logic [7:0]       new_ascii;
    logic             do_push;
    logic             do_pop;
    logic [17:0]      head;

`ifdef SCANCODE_ASCII_EN
    function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] ch;
        logic       letter;
        ch     = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
            8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
            8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
            8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
            8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
            8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
            default: letter = 1'b0;
        endcase
        if (!letter) begin
            case (code)
                8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;
                8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;
                8'h3E: ch = 8'h38;  8'h46: ch = 8'h39;
                8'h29: ch = 8'h20;  8'h5A: ch = 8'h0D;  8'h66: ch = 8'h08;
                default: ch = 8'h00;
            endcase
        end
        return (letter && shift) ? (ch - 8'h20) : ch;
    endfunction
`endif

    // Prefix parser: only bytes flagged by code_valid advance the FSM.
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        ev_gen     = 1'b0;
        new_ext    = 1'b0;
        new_rel    = 1'b0;
        new_code   = keycode;
        if (code_valid) begin
            case (state_q)
                ST_IDLE: begin
                    case (keycode)
                        8'hE0: state_d = ST_E0;
                        8'hF0: state_d = ST_F0;
                        8'hE1: begin state_d = ST_SKIP; skip_cnt_d = 3'd7; end
                        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_d = ST_IDLE;
                        default: ev_gen = 1'b1;
                    endcase
                end
                ST_E0: begin
                    case (keycode)
                        8'hF0: state_d = ST_E0F0;
                        8'hE0: state_d = ST_E0;
                        8'hE1: begin state_d = ST_SKIP; skip_cnt_d = 3'd7; end
                        default: begin ev_gen = 1'b1; new_ext = 1'b1; state_d = ST_IDLE; end
                    endcase
                end
                ST_F0, ST_E0F0: begin
                    case (keycode)
                        8'hE0: state_d = ST_E0;
                        8'hF0: state_d = ST_F0;
                        8'hE1: begin state_d = ST_SKIP; skip_cnt_d = 3'd7; end
                        default: begin
                            ev_gen  = 1'b1;
                            new_rel = 1'b1;
                            new_ext = (state_q == ST_E0F0);
                            state_d = ST_IDLE;
                        end
                    endcase
                end
                ST_SKIP: begin
                    if (skip_cnt_q <= 3'd1) begin
                        skip_cnt_d = 3'd0;
                        ev_gen     = 1'b1;
                        new_code   = 8'hE1;
                        state_d    = ST_IDLE;
                    end else begin
                        skip_cnt_d = skip_cnt_q - 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Shift flags follow non-extended 12/59 events whether or not the event fits in the FIFO.
    always_comb begin
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        if (ev_gen && !new_ext) begin
            if (new_code == 8'h12) shift_l_d = !new_rel;
            if (new_code == 8'h59) shift_r_d = !new_rel;
        end
    end

`ifdef SCANCODE_ASCII_EN
    assign new_ascii = new_ext ? 8'h00 : to_ascii(new_code, shift_l_q | shift_r_q);
`else
    assign new_ascii = 8'h00;
`endif

    always_comb begin
        do_pop     = ev_rd && (count_q != '0);
        do_push    = ev_gen && ((count_q != FULL_CNT) || do_pop);
        overflow_d = overflow_q | (ev_gen && !do_push);
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        mem_d      = mem_q;
        if (do_push) mem_d[wr_ptr_q] = {new_ext, new_rel, new_code, new_ascii};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
            shift_l_q  <= 1'b0;
            shift_r_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            shift_l_q  <= shift_l_d;
            shift_r_q  <= shift_r_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head fields are forced to 0 when empty so storage needs no reset.
    assign head       = mem_q[rd_ptr_q];
    assign ev_valid   = (count_q != '0);
    assign ev_ext     = ev_valid & head[17];
    assign ev_rel     = ev_valid & head[16];
    assign ev_code    = ev_valid ? head[15:8] : 8'h00;
    assign ev_ascii   = ev_valid ? head[7:0]  : 8'h00;
    assign ev_full    = (count_q == FULL_CNT);
    assign overflow   = overflow_q;
    assign shift_held = shift_l_q | shift_r_q;

endmodule
